// File: rtl/rs_age_ordered_pkg.sv
// rs_age_ordered_pkg
// Shared defaults for the age-ordered reservation station slice.
// No ports. Imported by the interface, the age matrix and the top.
//
// Tag encoding: tags are ROB_W+1 bits wide. The all-ones tag means
// "operand value already present".
package rs_age_ordered_pkg;

    localparam int ROB_W_DEF    = 3;
    localparam int OP_W_DEF     = 4;
    localparam int XLEN_DEF     = 32;
    localparam int RS_DEPTH_DEF = 8;
    localparam int CDB_NUM_DEF  = 2;

endpackage

// File: rtl/rs_age_ordered_if.sv
// rs_age_ordered_if
// Dispatch and issue handshake bundle between the decoder, the
// reservation station and the ALU.
//   disp_valid/disp_op_l1/disp_op_l2 : one decoded op per cycle
//   disp_q1/disp_q2                  : source tags, all-ones = value valid
//   disp_v1/disp_v2                  : source values (imm already in v2)
//   disp_rob_id                      : destination ROB index
//   iss_valid/iss_ready              : issue register handshake to the ALU
//   iss_op_l1/iss_op_l2/iss_opr1/iss_opr2/iss_tag : issued op
// Modports: master = dispatch/ALU side, slave = reservation station.
interface rs_age_ordered_if
    import rs_age_ordered_pkg::*;
#(
    parameter int ROB_W = ROB_W_DEF,
    parameter int OP_W  = OP_W_DEF,
    parameter int XLEN  = XLEN_DEF
) ();

    logic                 disp_valid;
    logic [OP_W-1:0]      disp_op_l1;
    logic                 disp_op_l2;
    logic [ROB_W:0]       disp_q1;
    logic [ROB_W:0]       disp_q2;
    logic [XLEN-1:0]      disp_v1;
    logic [XLEN-1:0]      disp_v2;
    logic [ROB_W-1:0]     disp_rob_id;

    logic                 iss_valid;
    logic                 iss_ready;
    logic [OP_W-1:0]      iss_op_l1;
    logic                 iss_op_l2;
    logic [XLEN-1:0]      iss_opr1;
    logic [XLEN-1:0]      iss_opr2;
    logic [ROB_W:0]       iss_tag;

    modport master (
        output disp_valid, disp_op_l1, disp_op_l2, disp_q1, disp_q2,
               disp_v1, disp_v2, disp_rob_id, iss_ready,
        input  iss_valid, iss_op_l1, iss_op_l2, iss_opr1, iss_opr2, iss_tag
    );

    modport slave (
        input  disp_valid, disp_op_l1, disp_op_l2, disp_q1, disp_q2,
               disp_v1, disp_v2, disp_rob_id, iss_ready,
        output iss_valid, iss_op_l1, iss_op_l2, iss_opr1, iss_opr2, iss_tag
    );

endinterface

// File: rtl/rs_age_ordered_age_matrix.sv
// rs_age_ordered_age_matrix
// DEPTH x DEPTH older-than matrix. older_q[i][j] = 1 means entry j is
// older than entry i. Picks the one-hot oldest entry among a request set.
//   clk_in, rst_in : clock, async active-high reset (clears the matrix)
//   en             : global enable, low freezes the matrix
//   clear          : flush, clears every bit
//   alloc          : one-hot entry being written this cycle
//   free           : one-hot entry leaving this cycle
//   busy           : occupancy before this edge
//   req            : candidate entries (subset of busy)
//   oldest         : one-hot oldest candidate, zero when req is zero
module rs_age_ordered_age_matrix
    import rs_age_ordered_pkg::*;
#(
    parameter int DEPTH = RS_DEPTH_DEF
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             en,
    input  logic             clear,
    input  logic [DEPTH-1:0] alloc,
    input  logic [DEPTH-1:0] free,
    input  logic [DEPTH-1:0] busy,
    input  logic [DEPTH-1:0] req,
    output logic [DEPTH-1:0] oldest
);

    logic [DEPTH-1:0][DEPTH-1:0] older_q;

    // A new entry is younger than every surviving entry, and nobody is
    // younger than it, so its column is wiped. Freed entries drop out of
    // both their row and their column so stale bits never block a select.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            older_q <= '0;
        end else if (en) begin
            if (clear) begin
                older_q <= '0;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    for (int j = 0; j < DEPTH; j++) begin
                        if (alloc[i])
                            older_q[i][j] <= busy[j] & ~free[j];
                        else if (alloc[j] || free[i] || free[j])
                            older_q[i][j] <= 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        oldest = '0;
        for (int i = 0; i < DEPTH; i++)
            oldest[i] = req[i] && ((older_q[i] & req) == '0);
    end

endmodule

// File: rtl/rs_age_ordered.sv
// rs_age_ordered
// Reservation station for the integer ALU path. Holds up to RS_DEPTH ops
// waiting on operand tags, snoops CDB_NUM result buses, and issues the
// oldest ready entry through a valid/ready output register.
//   clk_in, rst_in     : clock, async active-high reset
//   rdy_in             : global enable, low freezes all state
//   flush_in           : mispredict flush, drops every entry and the issue reg
//   bus                : dispatch in / issue out handshake (slave modport)
//   cdb_valid/tag/value: flattened result buses, channel k at slice k
//   full_out           : all entries occupied
//   count_out          : occupied entries
module rs_age_ordered
    import rs_age_ordered_pkg::*;
#(
    parameter int RS_DEPTH = RS_DEPTH_DEF,
    parameter int ROB_W    = ROB_W_DEF,
    parameter int CDB_NUM  = CDB_NUM_DEF,
    parameter int OP_W     = OP_W_DEF,
    parameter int XLEN     = XLEN_DEF
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic                              rdy_in,
    input  logic                              flush_in,
    rs_age_ordered_if.slave                   bus,
    input  logic [CDB_NUM-1:0]                cdb_valid,
    input  logic [CDB_NUM*(ROB_W+1)-1:0]      cdb_tag,
    input  logic [CDB_NUM*XLEN-1:0]           cdb_value,
    output logic                              full_out,
    output logic [$clog2(RS_DEPTH+1)-1:0]     count_out
);

    localparam int TAG_W = ROB_W + 1;
    localparam int CNT_W = $clog2(RS_DEPTH + 1);
    localparam logic [TAG_W-1:0] TAG_NONE = '1;

    logic [RS_DEPTH-1:0] busy_q;
    logic [OP_W-1:0]     op_l1_q [RS_DEPTH];
    logic [RS_DEPTH-1:0] op_l2_q;
    logic [TAG_W-1:0]    q1_q    [RS_DEPTH];
    logic [TAG_W-1:0]    q2_q    [RS_DEPTH];
    logic [XLEN-1:0]     v1_q    [RS_DEPTH];
    logic [XLEN-1:0]     v2_q    [RS_DEPTH];
    logic [ROB_W-1:0]    rob_q   [RS_DEPTH];
    logic [CNT_W-1:0]    count_q;

    logic                iss_valid_q;
    logic [OP_W-1:0]     iss_op_l1_q;
    logic                iss_op_l2_q;
    logic [XLEN-1:0]     iss_opr1_q;
    logic [XLEN-1:0]     iss_opr2_q;
    logic [TAG_W-1:0]    iss_tag_q;

    logic [RS_DEPTH-1:0] wake1, wake2;
    logic [XLEN-1:0]     wval1 [RS_DEPTH];
    logic [XLEN-1:0]     wval2 [RS_DEPTH];
    logic                byp1, byp2;
    logic [XLEN-1:0]     bval1, bval2;

    logic [RS_DEPTH-1:0] ready;
    logic [RS_DEPTH-1:0] oldest;
    logic [RS_DEPTH-1:0] free_oh;
    logic [RS_DEPTH-1:0] alloc_vec;
    logic [RS_DEPTH-1:0] issue_vec;
    logic                disp_ok;
    logic                issue_load;
    logic                issue_fire;

    logic [OP_W-1:0]     sel_op_l1;
    logic                sel_op_l2;
    logic [XLEN-1:0]     sel_v1, sel_v2;
    logic [ROB_W-1:0]    sel_rob;

    assign full_out  = (count_q == CNT_W'(RS_DEPTH));
    assign count_out = count_q;

    // Channels are scanned from the highest index down so that on a
    // duplicate tag the lowest channel is the last writer and wins.
    always_comb begin
        wake1 = '0;
        wake2 = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            wval1[i] = '0;
            wval2[i] = '0;
        end
        byp1  = 1'b0;
        byp2  = 1'b0;
        bval1 = '0;
        bval2 = '0;
        for (int k = CDB_NUM - 1; k >= 0; k--) begin
            if (cdb_valid[k]) begin
                for (int i = 0; i < RS_DEPTH; i++) begin
                    if (busy_q[i] && q1_q[i] != TAG_NONE && q1_q[i] == cdb_tag[k*TAG_W +: TAG_W]) begin
                        wake1[i] = 1'b1;
                        wval1[i] = cdb_value[k*XLEN +: XLEN];
                    end
                    if (busy_q[i] && q2_q[i] != TAG_NONE && q2_q[i] == cdb_tag[k*TAG_W +: TAG_W]) begin
                        wake2[i] = 1'b1;
                        wval2[i] = cdb_value[k*XLEN +: XLEN];
                    end
                end
                if (bus.disp_q1 != TAG_NONE && bus.disp_q1 == cdb_tag[k*TAG_W +: TAG_W]) begin
                    byp1  = 1'b1;
                    bval1 = cdb_value[k*XLEN +: XLEN];
                end
                if (bus.disp_q2 != TAG_NONE && bus.disp_q2 == cdb_tag[k*TAG_W +: TAG_W]) begin
                    byp2  = 1'b1;
                    bval2 = cdb_value[k*XLEN +: XLEN];
                end
            end
        end
    end

    always_comb begin
        ready = '0;
        for (int i = 0; i < RS_DEPTH; i++)
            ready[i] = busy_q[i] && (q1_q[i] == TAG_NONE) && (q2_q[i] == TAG_NONE);
    end

    // Lowest clear bit of busy, isolated as a one-hot.
    assign free_oh    = ~busy_q & (busy_q + {{(RS_DEPTH-1){1'b0}}, 1'b1});
    assign disp_ok    = bus.disp_valid && !full_out;
    assign alloc_vec  = disp_ok ? free_oh : '0;
    assign issue_load = !iss_valid_q || bus.iss_ready;
    assign issue_vec  = issue_load ? oldest : '0;
    assign issue_fire = |issue_vec;

    rs_age_ordered_age_matrix #(
        .DEPTH (RS_DEPTH)
    ) u_age (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .en     (rdy_in),
        .clear  (flush_in),
        .alloc  (alloc_vec),
        .free   (issue_vec),
        .busy   (busy_q),
        .req    (ready),
        .oldest (oldest)
    );

    always_comb begin
        sel_op_l1 = '0;
        sel_op_l2 = 1'b0;
        sel_v1    = '0;
        sel_v2    = '0;
        sel_rob   = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (oldest[i]) begin
                sel_op_l1 = op_l1_q[i];
                sel_op_l2 = op_l2_q[i];
                sel_v1    = v1_q[i];
                sel_v2    = v2_q[i];
                sel_rob   = rob_q[i];
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            busy_q  <= '0;
            op_l2_q <= '0;
            count_q <= '0;
            for (int i = 0; i < RS_DEPTH; i++) begin
                op_l1_q[i] <= '0;
                q1_q[i]    <= TAG_NONE;
                q2_q[i]    <= TAG_NONE;
                v1_q[i]    <= '0;
                v2_q[i]    <= '0;
                rob_q[i]   <= '0;
            end
            iss_valid_q <= 1'b0;
            iss_op_l1_q <= '0;
            iss_op_l2_q <= 1'b0;
            iss_opr1_q  <= '0;
            iss_opr2_q  <= '0;
            iss_tag_q   <= TAG_NONE;
        end else if (rdy_in) begin
            if (flush_in) begin
                busy_q      <= '0;
                count_q     <= '0;
                iss_valid_q <= 1'b0;
            end else begin
                for (int i = 0; i < RS_DEPTH; i++) begin
                    if (alloc_vec[i]) begin
                        busy_q[i]  <= 1'b1;
                        op_l1_q[i] <= bus.disp_op_l1;
                        op_l2_q[i] <= bus.disp_op_l2;
                        rob_q[i]   <= bus.disp_rob_id;
                        q1_q[i]    <= byp1 ? TAG_NONE : bus.disp_q1;
                        v1_q[i]    <= byp1 ? bval1 : bus.disp_v1;
                        q2_q[i]    <= byp2 ? TAG_NONE : bus.disp_q2;
                        v2_q[i]    <= byp2 ? bval2 : bus.disp_v2;
                    end else begin
                        if (issue_vec[i])
                            busy_q[i] <= 1'b0;
                        if (wake1[i]) begin
                            q1_q[i] <= TAG_NONE;
                            v1_q[i] <= wval1[i];
                        end
                        if (wake2[i]) begin
                            q2_q[i] <= TAG_NONE;
                            v2_q[i] <= wval2[i];
                        end
                    end
                end
                count_q <= count_q + CNT_W'(disp_ok) - CNT_W'(issue_fire);
                if (issue_load) begin
                    iss_valid_q <= issue_fire;
                    if (issue_fire) begin
                        iss_op_l1_q <= sel_op_l1;
                        iss_op_l2_q <= sel_op_l2;
                        iss_opr1_q  <= sel_v1;
                        iss_opr2_q  <= sel_v2;
                        iss_tag_q   <= {1'b0, sel_rob};
                    end
                end
            end
        end
    end

    assign bus.iss_valid = iss_valid_q;
    assign bus.iss_op_l1 = iss_op_l1_q;
    assign bus.iss_op_l2 = iss_op_l2_q;
    assign bus.iss_opr1  = iss_opr1_q;
    assign bus.iss_opr2  = iss_opr2_q;
    assign bus.iss_tag   = iss_tag_q;

    // Dispatching into a full station is a protocol violation upstream.
    a_no_disp_when_full: assert property (
        @(posedge clk_in) disable iff (rst_in)
        !(rdy_in && !flush_in && bus.disp_valid && full_out)
    ) else $error("rs_age_ordered: dispatch while full");

endmodule

// File: tb/tb_rs_age_ordered.sv
module tb_rs_age_ordered;
    import rs_age_ordered_pkg::*;

    localparam int RS_DEPTH = 8;
    localparam int ROB_W    = 3;
    localparam int CDB_NUM  = 2;
    localparam int OP_W     = 4;
    localparam int XLEN     = 32;
    localparam int TAG_W    = ROB_W + 1;
    localparam int CNT_W    = $clog2(RS_DEPTH + 1);
    localparam logic [TAG_W-1:0] NONE = '1;

    logic                     clk_in = 1'b0;
    logic                     rst_in;
    logic                     rdy_in;
    logic                     flush_in;
    logic [CDB_NUM-1:0]       cdb_valid;
    logic [CDB_NUM*TAG_W-1:0] cdb_tag;
    logic [CDB_NUM*XLEN-1:0]  cdb_value;
    logic                     full_out;
    logic [CNT_W-1:0]         count_out;

    rs_age_ordered_if #(.ROB_W(ROB_W), .OP_W(OP_W), .XLEN(XLEN)) bus ();

    rs_age_ordered #(
        .RS_DEPTH (RS_DEPTH),
        .ROB_W    (ROB_W),
        .CDB_NUM  (CDB_NUM),
        .OP_W     (OP_W),
        .XLEN     (XLEN)
    ) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .rdy_in    (rdy_in),
        .flush_in  (flush_in),
        .bus       (bus),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_value (cdb_value),
        .full_out  (full_out),
        .count_out (count_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [OP_W-1:0]  op1;
        logic             op2;
        logic [XLEN-1:0]  opr1;
        logic [XLEN-1:0]  opr2;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic push_exp(input logic [OP_W-1:0] op1, input logic op2,
                            input logic [XLEN-1:0] opr1, input logic [XLEN-1:0] opr2,
                            input logic [ROB_W-1:0] rob);
        exp_t e;
        e.op1 = op1; e.op2 = op2; e.opr1 = opr1; e.opr2 = opr2; e.tag = {1'b0, rob};
        exp_q.push_back(e);
    endtask

    task automatic disp(input logic [OP_W-1:0] op1, input logic op2,
                        input logic [TAG_W-1:0] q1, input logic [TAG_W-1:0] q2,
                        input logic [XLEN-1:0] v1, input logic [XLEN-1:0] v2,
                        input logic [ROB_W-1:0] rob);
        bus.disp_valid  = 1'b1;
        bus.disp_op_l1  = op1;
        bus.disp_op_l2  = op2;
        bus.disp_q1     = q1;
        bus.disp_q2     = q2;
        bus.disp_v1     = v1;
        bus.disp_v2     = v2;
        bus.disp_rob_id = rob;
        tick();
        bus.disp_valid  = 1'b0;
    endtask

    task automatic cdb_drive(input int ch, input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] val);
        cdb_valid[ch]                = 1'b1;
        cdb_tag[ch*TAG_W +: TAG_W]   = tag;
        cdb_value[ch*XLEN +: XLEN]   = val;
    endtask

    task automatic cdb_idle();
        cdb_valid = '0;
    endtask

    task automatic wait_drain(input int max_cycles);
        for (int c = 0; c < max_cycles && exp_q.size() != 0; c++)
            tick();
        check_val("drain", 64'(exp_q.size()), 64'd0);
    endtask

    // Issue monitor: inputs change just after the rising edge, so the
    // handshake is stable at the falling edge.
    always @(negedge clk_in) begin
        if (!rst_in && rdy_in && !flush_in && bus.iss_valid && bus.iss_ready) begin
            check_val("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check_val("iss_op_l1", 64'(bus.iss_op_l1), 64'(e.op1));
                check_val("iss_op_l2", 64'(bus.iss_op_l2), 64'(e.op2));
                check_val("iss_opr1",  64'(bus.iss_opr1),  64'(e.opr1));
                check_val("iss_opr2",  64'(bus.iss_opr2),  64'(e.opr2));
                check_val("iss_tag",   64'(bus.iss_tag),   64'(e.tag));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; flush_in = 1'b0;
        bus.disp_valid = 1'b0; bus.disp_op_l1 = '0; bus.disp_op_l2 = 1'b0;
        bus.disp_q1 = NONE; bus.disp_q2 = NONE; bus.disp_v1 = '0; bus.disp_v2 = '0;
        bus.disp_rob_id = '0; bus.iss_ready = 1'b1;
        cdb_valid = '0; cdb_tag = '0; cdb_value = '0;

        // reset state
        tick();
        check_val("rst_iss_valid", 64'(bus.iss_valid), 64'd0);
        check_val("rst_iss_tag",   64'(bus.iss_tag),   64'(NONE));
        check_val("rst_iss_opr1",  64'(bus.iss_opr1),  64'd0);
        check_val("rst_count",     64'(count_out),     64'd0);
        check_val("rst_full",      64'(full_out),      64'd0);
        tick();
        rst_in = 1'b0;

        // age order: A waits on tag 5, B is ready and issues first
        push_exp(4'h2, 1'b1, 32'h33, 32'h44, 3'd2);
        push_exp(4'h1, 1'b0, 32'h11, 32'h22, 3'd1);
        disp(4'h1, 1'b0, 4'd5, NONE, 32'h0, 32'h22, 3'd1);
        disp(4'h2, 1'b1, NONE, NONE, 32'h33, 32'h44, 3'd2);
        tick();
        cdb_drive(1, 4'd5, 32'h11);
        tick();
        cdb_idle();
        check_val("age_gap_valid", 64'(bus.iss_valid), 64'd0);
        tick();
        check_val("age_a_valid", 64'(bus.iss_valid), 64'd1);
        check_val("age_a_tag",   64'(bus.iss_tag),   64'd1);
        wait_drain(5);
        check_val("age_count", 64'(count_out), 64'd0);

        // oldest-first beats lowest index
        for (int i = 0; i < RS_DEPTH; i++)
            disp(4'h3, 1'b0, TAG_W'(i), NONE, 32'h0, 32'(i * 16), ROB_W'(i));
        check_val("fill_full",  64'(full_out),  64'd1);
        check_val("fill_count", 64'(count_out), 64'd8);
        push_exp(4'h3, 1'b0, 32'h200, 32'd32, 3'd2);
        cdb_drive(0, 4'd2, 32'h200);
        tick();
        cdb_idle();
        tick();
        check_val("slot2_count", 64'(count_out), 64'd7);
        check_val("slot2_full",  64'(full_out),  64'd0);
        push_exp(4'h3, 1'b0, 32'h600, 32'd96, 3'd6);
        push_exp(4'h4, 1'b1, 32'h77, 32'h88, 3'd3);
        cdb_drive(1, 4'd6, 32'h600);
        disp(4'h4, 1'b1, NONE, NONE, 32'h77, 32'h88, 3'd3);
        cdb_idle();
        wait_drain(6);
        check_val("oldest_count", 64'(count_out), 64'd6);
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
        check_val("flush1_count", 64'(count_out), 64'd0);

        // dispatch bypass, channel priority, double wakeup
        push_exp(4'h5, 1'b0, 32'h55, 32'hDEAD, 3'd4);
        cdb_drive(0, 4'd6, 32'hBAD);
        cdb_drive(1, 4'd3, 32'hDEAD);
        disp(4'h5, 1'b0, NONE, 4'd3, 32'h55, 32'h0, 3'd4);
        cdb_idle();
        push_exp(4'h6, 1'b0, 32'hAAAA, 32'h66, 3'd5);
        cdb_drive(0, 4'd4, 32'hAAAA);
        cdb_drive(1, 4'd4, 32'hBBBB);
        disp(4'h6, 1'b0, 4'd4, NONE, 32'h0, 32'h66, 3'd5);
        cdb_idle();
        wait_drain(6);
        push_exp(4'h7, 1'b1, 32'h700, 32'h800, 3'd6);
        disp(4'h7, 1'b1, 4'd7, 4'd8, 32'h0, 32'h0, 3'd6);
        cdb_drive(0, 4'd7, 32'h700);
        cdb_drive(1, 4'd8, 32'h800);
        tick();
        cdb_idle();
        wait_drain(6);

        // backpressure and global freeze
        bus.iss_ready = 1'b0;
        disp(4'h8, 1'b0, NONE, NONE, 32'h1001, 32'h1002, 3'd0);
        disp(4'h9, 1'b1, NONE, NONE, 32'h2001, 32'h2002, 3'd7);
        for (int c = 0; c < 4; c++) begin
            check_val("bp_valid", 64'(bus.iss_valid), 64'd1);
            check_val("bp_opr1",  64'(bus.iss_opr1),  64'h1001);
            check_val("bp_tag",   64'(bus.iss_tag),   64'd0);
            check_val("bp_count", 64'(count_out),     64'd1);
            tick();
        end
        rdy_in = 1'b0;
        disp(4'hA, 1'b0, NONE, NONE, 32'h3001, 32'h3002, 3'd5);
        check_val("freeze_count", 64'(count_out), 64'd1);
        rdy_in = 1'b1;
        push_exp(4'h8, 1'b0, 32'h1001, 32'h1002, 3'd0);
        push_exp(4'h9, 1'b1, 32'h2001, 32'h2002, 3'd7);
        bus.iss_ready = 1'b1;
        tick();
        check_val("bp_next_valid", 64'(bus.iss_valid), 64'd1);
        check_val("bp_next_tag",   64'(bus.iss_tag),   64'd7);
        wait_drain(4);
        check_val("bp_count_end", 64'(count_out), 64'd0);

        // full then flush, late CDB writes must not issue anything
        for (int i = 0; i < RS_DEPTH; i++)
            disp(4'hB, 1'b0, TAG_W'(i), NONE, 32'h0, 32'h0, ROB_W'(i));
        check_val("full_flag", 64'(full_out), 64'd1);
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
        check_val("flush_count", 64'(count_out),     64'd0);
        check_val("flush_full",  64'(full_out),      64'd0);
        check_val("flush_valid", 64'(bus.iss_valid), 64'd0);
        for (int i = 0; i < RS_DEPTH; i++) begin
            cdb_drive(0, TAG_W'(i), 32'(i));
            tick();
        end
        cdb_idle();
        tick();
        tick();
        check_val("late_cdb_valid", 64'(bus.iss_valid), 64'd0);
        check_val("late_cdb_count", 64'(count_out),     64'd0);

        // asynchronous reset in the middle of traffic
        bus.iss_ready = 1'b0;
        disp(4'hC, 1'b0, NONE, NONE, 32'h1, 32'h2, 3'd2);
        disp(4'hD, 1'b0, 4'd1, NONE, 32'h0, 32'h0, 3'd3);
        disp(4'hD, 1'b0, 4'd2, NONE, 32'h0, 32'h0, 3'd4);
        disp(4'hD, 1'b0, 4'd3, NONE, 32'h0, 32'h0, 3'd5);
        check_val("pre_rst_count", 64'(count_out),     64'd3);
        check_val("pre_rst_valid", 64'(bus.iss_valid), 64'd1);
        #2;
        rst_in = 1'b1;
        #1;
        check_val("mid_rst_valid", 64'(bus.iss_valid), 64'd0);
        check_val("mid_rst_count", 64'(count_out),     64'd0);
        check_val("mid_rst_full",  64'(full_out),      64'd0);
        check_val("mid_rst_tag",   64'(bus.iss_tag),   64'(NONE));
        #2;
        rst_in = 1'b0;
        tick();
        bus.iss_ready = 1'b1;
        push_exp(4'hE, 1'b1, 32'hCAFE, 32'hF00D, 3'd1);
        disp(4'hE, 1'b1, NONE, NONE, 32'hCAFE, 32'hF00D, 3'd1);
        wait_drain(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
